min_max_finder_param: RTL and testbench
=======================================

// Module: min_max_finder_param
// PURPOSE
//  Parametrised successor to the EE457 16x8 min/max finder. Holds a DEPTH x WIDTH
//  internal array and, on Start, scans it once, one element per clock, with two
//  comparators. Reports Max, Min and the index of the first occurrence of each.
//  Unsigned or signed compare. Array is loadable through a write port.
//  Done/Ack handshake so a host or testbench can run back-to-back tests.
// PARAMETERS
//  WIDTH      8    data width of each array element (>=2)
//  DEPTH      16   number of array elements (>=1)
//  SIGNED_CMP 0    0: unsigned compare; 1: two's-complement compare
//  ADDR_W     $clog2(DEPTH) (min 1)   index width; derived, not overridden
// PORTS
//  Clk      in   1       clock, all state updates on posedge
//  Reset_n  in   1       async active-low reset
//  We       in   1       array write enable (honoured only in INI or DONE)
//  Waddr    in   ADDR_W  array write address; writes with Waddr>=DEPTH ignored
//  Wdata    in   WIDTH   array write data
//  Start    in   1       begin scan; sampled only in INI
//  Ack      in   1       host acknowledges result; sampled only in DONE
//  Max      out  WIDTH   maximum value found
//  Min      out  WIDTH   minimum value found
//  Max_idx  out  ADDR_W  index of first occurrence of Max
//  Min_idx  out  ADDR_W  index of first occurrence of Min
//  Qi,Ql,Qc,Qd out 1 each  one-hot state: INI, LOAD, CMP, DONE
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=INI, I=0, Max=Min=0, Max_idx=Min_idx=0.
//   The array contents are NOT cleared. Reset mid-scan aborts the scan immediately.
//  INI:  accept writes. Start=1 -> LOAD. Max/Min/idx hold previous results.
//  LOAD: Max=Min=M[0], Max_idx=Min_idx=0, I=1.
//        DEPTH==1 -> DONE; else -> CMP.
//  CMP:  each clock compares M[I] against Max and Min in parallel.
//        M[I]>Max (strict) -> Max=M[I], Max_idx=I.
//        M[I]<Min (strict) -> Min=M[I], Min_idx=I.
//        Both updates use pre-clock Max/Min. Ties never update, so the first
//        occurrence wins.
//        I==DEPTH-1 -> DONE; else I=I+1. I never wraps past DEPTH-1.
//  DONE: outputs stable; accept writes. Ack=1 -> INI. Start is ignored here.
//  Latency: Qd rises DEPTH+1 clocks after the edge that samples Start
//   (1 LOAD + DEPTH-1 CMP + entry into DONE). Latency is data independent.
//  Writes in LOAD/CMP are dropped, so the array is frozen during a scan.
//   A write in INI on the same edge as Start is performed, and LOAD sees it
//   on the next clock.
//  Compare: SIGNED_CMP=1 uses $signed on both operands. No arithmetic, no overflow.
//  Start and Ack held high are level-sampled only in their own state. A held
//   Start re-launches from INI; a held Ack is ignored outside DONE.
// STRUCTURE
//  Shared package min_max_pkg: state encoding localparams (one-hot S_INI,
//   S_LOAD, S_CMP, S_DONE) and a clog2-with-min-1 function. Share these with the
//   existing part-3 designs and benches.
//  One sub-module: min_max_cmp_unit. It is a combinational dual comparator
//   (WIDTH, SIGNED_CMP) that outputs gt_max and lt_min, instantiated once.
//  The array is a reg array M[0:DEPTH-1] named M, so benches can still
//   initialise it hierarchically via UUT.M[i].
// TESTING
//  1 Defaults. Load F5,84,02,02,99,02,85,F4,F4,23,83,90,F4,64,9A,3B (M[15]..M[0]),
//    then Start -> Max=F5, Max_idx=15, Min=02, Min_idx=10.
//    Qd rises exactly 17 clocks after Start is sampled.
//  2 Ties. All 16 entries=5A -> Max=Min=5A, Max_idx=Min_idx=0.
//    Array with 01 at indices 3 and 9 -> Min_idx=3.
//  3 SIGNED_CMP=1. M[0]=00, M[5]=80, M[9]=7F, rest 10 -> Max=7F/9, Min=80/5.
//    The same data with SIGNED_CMP=0 -> Max=80/5, Min=00/0.
//  4 DEPTH=1, WIDTH=12. M[0]=ABC -> LOAD then DONE in 2 clocks; Max=Min=ABC, idx=0.
//    DEPTH=5: an index never exceeds 4.
//  5 Protocol. A write of FF to M[2] during CMP is dropped (result unchanged).
//    Start held high through DONE does not restart until Ack returns to INI.
//  6 Reset_n pulsed low at CMP with I=7 -> state INI and outputs 0 in the same
//    cycle. A rerun with unchanged array gives the same results as test 1.

Source files
------------

// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max finder family: one-hot state encoding and
// an index-width helper that never returns zero.
package min_max_pkg;

  typedef enum logic [3:0] {
    S_INI  = 4'b0001,
    S_LOAD = 4'b0010,
    S_CMP  = 4'b0100,
    S_DONE = 4'b1000
  } state_e;

  // Index width for n elements; a single-element array still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/min_max_cmp_unit.sv
// Dual comparator: flags a candidate element that strictly beats the running
// maximum or strictly undercuts the running minimum.
module min_max_cmp_unit #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic [WIDTH-1:0] elem,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [WIDTH-1:0] cur_min,
  output logic             gt_max,
  output logic             lt_min
);

  generate
    if (SIGNED_CMP != 0) begin : gen_signed
      assign gt_max = $signed(elem) > $signed(cur_max);
      assign lt_min = $signed(elem) < $signed(cur_min);
    end else begin : gen_unsigned
      assign gt_max = elem > cur_max;
      assign lt_min = elem < cur_min;
    end
  endgenerate

endmodule

// File: rtl/min_max_finder_param.sv
// Parametrised min/max finder: scans a writable DEPTH x WIDTH array one element
// per clock after Start, reports extremes and first-occurrence indices.
module min_max_finder_param
  import min_max_pkg::*;
#(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned SIGNED_CMP = 0,
  localparam int unsigned ADDR_W     = clog2_min1(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              We,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [WIDTH-1:0]  Wdata,
  input  logic              Start,
  input  logic              Ack,
  output logic [WIDTH-1:0]  Max,
  output logic [WIDTH-1:0]  Min,
  output logic [ADDR_W-1:0] Max_idx,
  output logic [ADDR_W-1:0] Min_idx,
  output logic              Qi,
  output logic              Ql,
  output logic              Qc,
  output logic              Qd
);

  logic [WIDTH-1:0] M [0:DEPTH-1];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic [WIDTH-1:0]  min_q, min_d;
  logic [ADDR_W-1:0] max_idx_q, max_idx_d;
  logic [ADDR_W-1:0] min_idx_q, min_idx_d;

  logic              wr_en_c;
  logic              last_c;
  logic [WIDTH-1:0]  elem_c;
  logic              gt_max;
  logic              lt_min;

  // Array is frozen during a scan; out-of-range addresses are dropped.
  assign wr_en_c = We && ((state_q == S_INI) || (state_q == S_DONE)) &&
                   (32'(Waddr) < DEPTH);

  always_ff @(posedge Clk) begin
    if (wr_en_c) begin
      M[Waddr] <= Wdata;
    end
  end

  assign elem_c = M[i_q];
  assign last_c = (i_q == ADDR_W'(DEPTH - 1));

  min_max_cmp_unit #(
    .WIDTH      (WIDTH),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp (
    .elem    (elem_c),
    .cur_max (max_q),
    .cur_min (min_q),
    .gt_max  (gt_max),
    .lt_min  (lt_min)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_INI;
      i_q       <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
    end
  end

  // Next-state and datapath; strict compares keep the first occurrence.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    case (state_q)
      S_INI: begin
        if (Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        max_d     = M[0];
        min_d     = M[0];
        max_idx_d = '0;
        min_idx_d = '0;
        i_d       = ADDR_W'(1);
        state_d   = (DEPTH == 1) ? S_DONE : S_CMP;
      end
      S_CMP: begin
        if (gt_max) begin
          max_d     = elem_c;
          max_idx_d = i_q;
        end
        if (lt_min) begin
          min_d     = elem_c;
          min_idx_d = i_q;
        end
        if (last_c) state_d = S_DONE;
        else        i_d     = i_q + ADDR_W'(1);
      end
      S_DONE: begin
        if (Ack) state_d = S_INI;
      end
      default: state_d = S_INI;
    endcase
  end

  assign Max     = max_q;
  assign Min     = min_q;
  assign Max_idx = max_idx_q;
  assign Min_idx = min_idx_q;
  assign Qi      = (state_q == S_INI);
  assign Ql      = (state_q == S_LOAD);
  assign Qc      = (state_q == S_CMP);
  assign Qd      = (state_q == S_DONE);

endmodule

// File: tb/tb_min_max_finder_param.sv
// Directed bench for min_max_finder_param: unsigned/signed 16x8 pair on shared
// inputs, plus DEPTH=1 (WIDTH=12) and DEPTH=5 instances.
module tb_min_max_finder_param;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset_n;
  int   errors = 0;
  int   checks = 0;

  // 16x8 instances (u0 unsigned, u1 signed) share every input
  logic       we, start, ack;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic [7:0] max0, min0, max1, min1;
  logic [3:0] maxi0, mini0, maxi1, mini1;
  logic       qi0, ql0, qc0, qd0, qi1, ql1, qc1, qd1;

  // DEPTH=1, WIDTH=12
  logic        we2, start2, ack2;
  logic [0:0]  waddr2;
  logic [11:0] wdata2, max2, min2;
  logic [0:0]  maxi2, mini2;
  logic        qi2, ql2, qc2, qd2;

  // DEPTH=5, WIDTH=8
  logic       we3, start3, ack3;
  logic [2:0] waddr3, maxi3, mini3;
  logic [7:0] wdata3, max3, min3;
  logic       qi3, ql3, qc3, qd3;

  min_max_finder_param UUT (
    .Clk(Clk), .Reset_n(Reset_n), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Start(start), .Ack(ack), .Max(max0), .Min(min0), .Max_idx(maxi0),
    .Min_idx(mini0), .Qi(qi0), .Ql(ql0), .Qc(qc0), .Qd(qd0));

  min_max_finder_param #(.SIGNED_CMP(1)) u_signed (
    .Clk(Clk), .Reset_n(Reset_n), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Start(start), .Ack(ack), .Max(max1), .Min(min1), .Max_idx(maxi1),
    .Min_idx(mini1), .Qi(qi1), .Ql(ql1), .Qc(qc1), .Qd(qd1));

  min_max_finder_param #(.WIDTH(12), .DEPTH(1)) u_d1 (
    .Clk(Clk), .Reset_n(Reset_n), .We(we2), .Waddr(waddr2), .Wdata(wdata2),
    .Start(start2), .Ack(ack2), .Max(max2), .Min(min2), .Max_idx(maxi2),
    .Min_idx(mini2), .Qi(qi2), .Ql(ql2), .Qc(qc2), .Qd(qd2));

  min_max_finder_param #(.DEPTH(5)) u_d5 (
    .Clk(Clk), .Reset_n(Reset_n), .We(we3), .Waddr(waddr3), .Wdata(wdata3),
    .Start(start3), .Ack(ack3), .Max(max3), .Min(min3), .Max_idx(maxi3),
    .Min_idx(mini3), .Qi(qi3), .Ql(ql3), .Qc(qc3), .Qd(qd3));

  typedef struct packed {
    logic [15:0][7:0] data;   // data[i] is M[i]
    logic [7:0]       umax, umin;
    logic [3:0]       umaxi, umini;
    logic [7:0]       smax, smin;
    logic [3:0]       smaxi, smini;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load16(input logic [15:0][7:0] d);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      we = 1'b1; waddr = 4'(i); wdata = d[i];
    end
    @(negedge Clk);
    we = 1'b0;
  endtask

  // Counts edges from (and including) the one that samples Start until Qd is high.
  task automatic scan0(input bit hold, output int n);
    @(negedge Clk);
    start = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      n++;
      if (!hold) start = 1'b0;
      if (qd0) break;
    end
  endtask

  task automatic wait_qd0(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      n++;
      if (qd0) break;
    end
  endtask

  task automatic ack0();
    @(negedge Clk); ack = 1'b1;
    @(negedge Clk); ack = 1'b0;
  endtask

  task automatic chk_res(input string nm, input vec_t v);
    chk({nm, " umax"},  32'(max0),  32'(v.umax));
    chk({nm, " umaxi"}, 32'(maxi0), 32'(v.umaxi));
    chk({nm, " umin"},  32'(min0),  32'(v.umin));
    chk({nm, " umini"}, 32'(mini0), 32'(v.umini));
    chk({nm, " smax"},  32'(max1),  32'(v.smax));
    chk({nm, " smaxi"}, 32'(maxi1), 32'(v.smaxi));
    chk({nm, " smin"},  32'(min1),  32'(v.smin));
    chk({nm, " smini"}, 32'(mini1), 32'(v.smini));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    vec_t v;

    vecs[0] = '{data: {8'hF5, 8'h84, 8'h02, 8'h02, 8'h99, 8'h02, 8'h85, 8'hF4,
                       8'hF4, 8'h23, 8'h83, 8'h90, 8'hF4, 8'h64, 8'h9A, 8'h3B},
                umax: 8'hF5, umaxi: 4'd15, umin: 8'h02, umini: 4'd10,
                smax: 8'h64, smaxi: 4'd2,  smin: 8'h83, smini: 4'd5};
    vecs[1] = '{data: {16{8'h5A}},
                umax: 8'h5A, umaxi: 4'd0, umin: 8'h5A, umini: 4'd0,
                smax: 8'h5A, smaxi: 4'd0, smin: 8'h5A, smini: 4'd0};
    vecs[2] = '{data: {8'h40, 8'h40, 8'h40, 8'h70, 8'h40, 8'h40, 8'h01, 8'h40,
                       8'h40, 8'h40, 8'h40, 8'h70, 8'h01, 8'h40, 8'h40, 8'h40},
                umax: 8'h70, umaxi: 4'd4, umin: 8'h01, umini: 4'd3,
                smax: 8'h70, smaxi: 4'd4, smin: 8'h01, smini: 4'd3};
    vecs[3] = '{data: {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h7F, 8'h10,
                       8'h10, 8'h10, 8'h80, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00},
                umax: 8'h80, umaxi: 4'd5, umin: 8'h00, umini: 4'd0,
                smax: 8'h7F, smaxi: 4'd9, smin: 8'h80, smini: 4'd5};
    vecs[4] = '{data: {8'h81, {14{8'h20}}, 8'h7E},
                umax: 8'h81, umaxi: 4'd15, umin: 8'h20, umini: 4'd1,
                smax: 8'h7E, smaxi: 4'd0,  smin: 8'h81, smini: 4'd15};

    Reset_n = 1'b0;
    we = 0; start = 0; ack = 0; waddr = '0; wdata = '0;
    we2 = 0; start2 = 0; ack2 = 0; waddr2 = '0; wdata2 = '0;
    we3 = 0; start3 = 0; ack3 = 0; waddr3 = '0; wdata3 = '0;
    #12;
    chk("reset Qi", 32'(qi0), 32'd1);
    chk("reset Qd", 32'(qd0), 32'd0);
    chk("reset Max", 32'(max0), 32'd0);
    chk("reset Min", 32'(min0), 32'd0);
    chk("reset Max_idx", 32'(maxi0), 32'd0);
    chk("reset Min_idx", 32'(mini0), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Table-driven scans on the 16x8 pair
    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      load16(v.data);
      scan0(1'b0, n);
      chk($sformatf("vec%0d latency", t), 32'(n), 32'd17);
      chk_res($sformatf("vec%0d", t), v);
      ack0();
    end

    // Write of FF to M[2] during the scan must be dropped
    load16(vecs[0].data);
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    we = 1'b1; waddr = 4'd2; wdata = 8'hFF;
    repeat (12) @(posedge Clk);
    @(negedge Clk);
    we = 1'b0;
    wait_qd0(n);
    chk("midscan write done", 32'(qd0), 32'd1);
    chk_res("midscan write", vecs[0]);
    ack0();
    scan0(1'b0, n);
    chk_res("rescan after drop", vecs[0]);
    ack0();

    // Start held through DONE: no restart until Ack returns to INI
    scan0(1'b1, n);
    chk("held start latency", 32'(n), 32'd17);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      if (qd0) n++;
    end
    chk("held start stays DONE", 32'(n), 32'd4);
    @(negedge Clk);
    ack = 1'b1;
    @(posedge Clk); #1;
    chk("ack to INI", 32'(qi0), 32'd1);
    @(posedge Clk); #1;
    chk("held start relaunch", 32'(ql0), 32'd1);
    @(negedge Clk);
    ack = 1'b0; start = 1'b0;
    wait_qd0(n);
    chk("relaunch latency", 32'(n), 32'd16);
    chk_res("relaunch", vecs[0]);
    ack0();

    // Async reset at CMP with I=7, then rerun on the unchanged array
    @(negedge Clk);
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      start = 1'b0;
    end
    @(negedge Clk);
    chk("pre-reset in CMP", 32'(qc0), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("abort Qi", 32'(qi0), 32'd1);
    chk("abort Qc", 32'(qc0), 32'd0);
    chk("abort Max", 32'(max0), 32'd0);
    chk("abort Min", 32'(min0), 32'd0);
    chk("abort Max_idx", 32'(maxi0), 32'd0);
    chk("abort Min_idx", 32'(mini0), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    scan0(1'b0, n);
    chk("post-reset latency", 32'(n), 32'd17);
    chk_res("post-reset rerun", vecs[0]);
    ack0();

    // Write in INI on the Start edge is seen by LOAD
    @(negedge Clk);
    we = 1'b1; waddr = 4'd0; wdata = 8'hFE; start = 1'b1;
    @(posedge Clk); #1;
    we = 1'b0; start = 1'b0;
    wait_qd0(n);
    v = vecs[0];
    v.umax = 8'hFE; v.umaxi = 4'd0;
    chk_res("same-edge write", v);
    ack0();

    // DEPTH=1, WIDTH=12
    @(negedge Clk); we2 = 1'b1; waddr2 = 1'b0; wdata2 = 12'hABC;
    @(negedge Clk); waddr2 = 1'b1; wdata2 = 12'h123;
    @(negedge Clk); we2 = 1'b0; start2 = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      n++; start2 = 1'b0;
      if (qd2) break;
    end
    chk("d1 latency", 32'(n), 32'd2);
    chk("d1 Max", 32'(max2), 32'hABC);
    chk("d1 Min", 32'(min2), 32'hABC);
    chk("d1 Max_idx", 32'(maxi2), 32'd0);
    chk("d1 Min_idx", 32'(mini2), 32'd0);

    // DEPTH=5: extremes at the last and a middle index, invalid addresses dropped
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      we3 = 1'b1; waddr3 = 3'(i);
      case (i)
        0: wdata3 = 8'h10;
        1: wdata3 = 8'h20;
        2: wdata3 = 8'h05;
        3: wdata3 = 8'h30;
        4: wdata3 = 8'hF0;
        default: wdata3 = 8'h00;
      endcase
    end
    @(negedge Clk); we3 = 1'b0; start3 = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      n++; start3 = 1'b0;
      if (qd3) break;
    end
    chk("d5 latency", 32'(n), 32'd6);
    chk("d5 Max", 32'(max3), 32'hF0);
    chk("d5 Max_idx", 32'(maxi3), 32'd4);
    chk("d5 Min", 32'(min3), 32'h05);
    chk("d5 Min_idx", 32'(mini3), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
